// File: rtl/md_unit_pkg.sv
// Shared operation codes, default latencies and the divide helper for the HI/LO
// multiply/divide unit.
package md_unit_pkg;

  typedef enum logic [4:0] {
    MD_NOP   = 5'd0,
    MD_MULT  = 5'd1,
    MD_MULTU = 5'd2,
    MD_DIV   = 5'd3,
    MD_DIVU  = 5'd4,
    MD_MTHI  = 5'd5,
    MD_MTLO  = 5'd6
  } md_op_e;

  localparam int MD_MULT_CYC = 5;
  localparam int MD_DIV_CYC  = 10;

  // True for the four ops that go through the multi-cycle start/busy handshake.
  function automatic logic md_is_arith(input logic [4:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Returns {remainder, quotient}. Signed mode divides magnitudes and then fixes
  // signs, so the quotient truncates toward zero and the remainder follows the
  // dividend; 0x80000000 / -1 wraps back to 0x80000000 with a zero remainder.
  function automatic logic [63:0] md_divide(input logic is_signed,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] quo;
    logic [31:0] rem;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    abs_a = neg_a ? (~a + 32'd1) : a;
    abs_b = neg_b ? (~b + 32'd1) : b;
    if (abs_b == 32'd0) begin
      quo = 32'd0;
      rem = 32'd0;
    end else begin
      quo = abs_a / abs_b;
      rem = abs_a % abs_b;
    end
    if (neg_a ^ neg_b) quo = ~quo + 32'd1;
    if (neg_a)         rem = ~rem + 32'd1;
    return {rem, quo};
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide responder owning HI/LO. Results are computed at
// accept time, held in pending registers and committed when the busy count expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYC,
  parameter int DIV_CYCLES  = MD_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [4:0]  mlu_op,
  input  logic        start,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             div0_q, div0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] div_s;
  logic        [63:0] div_u;
  logic               accept;

  assign prod_s = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
  assign prod_u = {32'd0, D1} * {32'd0, D2};
  assign div_s  = md_divide(1'b1, D1, D2);
  assign div_u  = md_divide(1'b0, D1, D2);

  // Undefined op codes are never accepted, even if start is (wrongly) raised.
  assign accept = start && !pause && !busy_q && md_is_arith(mlu_op);

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    div0_d    = div0_q;
    cnt_d     = cnt_q;

    if (cnt_q != '0) begin
      // In flight: pause and new requests are ignored; commit on the 1->0 step.
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1) && !div0_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (accept) begin
      div0_d = 1'b0;
      case (mlu_op)
        MD_MULT: begin
          pend_hi_d = prod_s[63:32];
          pend_lo_d = prod_s[31:0];
          cnt_d     = CNT_W'(MULT_CYCLES);
        end
        MD_MULTU: begin
          pend_hi_d = prod_u[63:32];
          pend_lo_d = prod_u[31:0];
          cnt_d     = CNT_W'(MULT_CYCLES);
        end
        MD_DIV: begin
          pend_hi_d = div_s[63:32];
          pend_lo_d = div_s[31:0];
          div0_d    = (D2 == 32'd0);
          cnt_d     = CNT_W'(DIV_CYCLES);
        end
        default: begin
          pend_hi_d = div_u[63:32];
          pend_lo_d = div_u[31:0];
          div0_d    = (D2 == 32'd0);
          cnt_d     = CNT_W'(DIV_CYCLES);
        end
      endcase
    end else if (!start && !pause) begin
      if (mlu_op == MD_MTHI) hi_d = D1;
      if (mlu_op == MD_MTLO) lo_d = D1;
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      div0_q    <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      div0_q    <= div0_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: each step drives inputs, clocks once and checks
// HI/LO/busy against hand-computed values.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pause;
  logic [31:0] D1;
  logic [31:0] D2;
  logic [4:0]  mlu_op;
  logic        start;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  md_unit dut (
    .clk    (clk),
    .reset  (reset),
    .pause  (pause),
    .D1     (D1),
    .D2     (D2),
    .mlu_op (mlu_op),
    .start  (start),
    .HI     (HI),
    .LO     (LO),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag, input logic b,
                             input logic [31:0] hi_e, input logic [31:0] lo_e);
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, ".hi"}, HI, hi_e);
    check({tag, ".lo"}, LO, lo_e);
  endtask

  // Issue one arithmetic op; busy must hold for n cycles with old HI/LO, then
  // the new values appear in the first cycle busy is low.
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    mlu_op = op; D1 = a; D2 = b; start = 1'b1;
    tick();
    start = 1'b0; mlu_op = MD_NOP;
    for (int i = 0; i < n; i++) begin
      check_state($sformatf("%s.c%0d", tag, i + 1), 1'b1, old_hi, old_lo);
      tick();
    end
    check_state({tag, ".done"}, 1'b0, new_hi, new_lo);
  endtask

  initial begin
    reset = 1'b0; pause = 1'b0; D1 = '0; D2 = '0; mlu_op = MD_NOP; start = 1'b0;
    tick();
    tick();
    check_state("reset", 1'b0, 32'h0, 32'h0);
    reset = 1'b1;

    run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5,
           32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10,
           32'hFFFFFFFF, 32'hFFFFFFFA, 32'd2, 32'd14);
    run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 10,
           32'd2, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10,
           32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 32'h80000000);

    mlu_op = MD_MTHI; D1 = 32'h11;
    tick();
    check_state("mthi11", 1'b0, 32'h11, 32'h80000000);
    mlu_op = MD_MTLO; D1 = 32'h22;
    tick();
    check_state("mtlo22", 1'b0, 32'h11, 32'h22);
    run_op("div0", MD_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22);
    run_op("divu0", MD_DIVU, 32'd9, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22);

    pause = 1'b1; start = 1'b1; mlu_op = MD_MULT; D1 = 32'd3; D2 = 32'd4;
    tick();
    check_state("pause_mult", 1'b0, 32'h11, 32'h22);
    start = 1'b0; mlu_op = MD_MTLO; D1 = 32'h55;
    tick();
    check_state("pause_mtlo", 1'b0, 32'h11, 32'h22);
    pause = 1'b0; mlu_op = MD_NOP;

    start = 1'b1; mlu_op = MD_MULT; D1 = 32'd3; D2 = 32'd4;
    tick();
    start = 1'b0; mlu_op = MD_NOP;
    check_state("abort.c1", 1'b1, 32'h11, 32'h22);
    tick();
    tick();
    check_state("abort.c3", 1'b1, 32'h11, 32'h22);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_state("abort.rst", 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    check_state("abort.after", 1'b0, 32'h0, 32'h0);

    mlu_op = MD_MTHI; D1 = 32'hABCD;
    tick();
    check_state("mthi_abcd", 1'b0, 32'hABCD, 32'h0);

    start = 1'b1; mlu_op = MD_MULT; D1 = 32'd7; D2 = 32'd6;
    tick();
    start = 1'b0; mlu_op = MD_MTLO; D1 = 32'h55;
    for (int i = 0; i < 5; i++) begin
      check_state($sformatf("mtlo_busy.c%0d", i + 1), 1'b1, 32'hABCD, 32'h0);
      if (i == 4) mlu_op = MD_NOP;
      tick();
    end
    check_state("mtlo_busy.done", 1'b0, 32'h0, 32'h2A);

    run_op("b2b", MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
           32'h0, 32'h2A, 32'h0, 32'h1);
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5,
           32'h0, 32'h1, 32'h1, 32'hFFFFFFFE);

    mlu_op = 5'd7; D1 = 32'h99;
    tick();
    check_state("bad_op", 1'b0, 32'h1, 32'hFFFFFFFE);
    mlu_op = MD_NOP;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
